dram_bus_arbiter: RTL

Two-master, one-slave arbiter that shares the SoC's single-port data RAM between the core load/store port (master 0) and the debug/program loader (master 1). It sits between those masters and the RAM instance inside `riscv_soc`. It grants at most one access per cycle and routes the one-cycle-latency read data back to the master that issued the read. It supports a bounded bus lock so the loader can write bursts.

---
 rtl/soc_bus_pkg.sv | 26 ++
 rtl/rr_pick2.sv | 34 +++
 rtl/dram_bus_arbiter.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/soc_bus_pkg.sv
// ============================================================================
// Module      : soc_bus_pkg
// Description : Shared SoC bus definitions: the arbiter state encoding,
//               the master indices and the default address/data widths.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package soc_bus_pkg;

  localparam int DEFAULT_AW = 32;
  localparam int DEFAULT_DW = 32;

  // Index of each master on the shared data-RAM port
  localparam logic M_CORE   = 1'b0;
  localparam logic M_LOADER = 1'b1;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_OWN0 = 2'd1,
    ARB_OWN1 = 2'd2
  } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/rr_pick2.sv
// ============================================================================
// Module      : rr_pick2
// Description : Two-way request picker. With ROUND_ROBIN set, a tie goes to
//               the master that was not granted last; otherwise master 0
//               always wins a tie.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick2 #(
  parameter bit ROUND_ROBIN = 1'b0
) (
  input  logic [1:0] req,
  input  logic       last,   // index of the master granted most recently
  output logic [1:0] pick    // one-hot winner, zero when nobody requests
);

  logic tie_to_m1;

  assign tie_to_m1 = ROUND_ROBIN && !last;

  // Resolve the winner; single requesters win outright
  always_comb begin
    pick = 2'b00;
    if (req == 2'b11) begin
      pick = tie_to_m1 ? 2'b10 : 2'b01;
    end else begin
      pick = req;
    end
  end

endmodule

`default_nettype wire

// File: rtl/dram_bus_arbiter.sv
// ============================================================================
// Module      : dram_bus_arbiter
// Description : Shares the single-port data RAM between the core load/store
//               port (m0) and the debug/program loader (m1). Combinational
//               grant, one-cycle read return routed to the issuing master,
//               and a bounded bus lock for loader write bursts.
//               Build option: ARB_ROUND_ROBIN_EN selects round-robin tie
//               breaking; without it m0 has fixed priority.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dram_bus_arbiter
  import soc_bus_pkg::*;
#(
  parameter int AW       = DEFAULT_AW,
  parameter int DW       = DEFAULT_DW,
  parameter int LOCK_MAX = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  input  logic          m1_lock,
  output logic          m0_gnt,
  output logic          m1_gnt,
  output logic          m0_rvalid,
  output logic          m1_rvalid,
  output logic [DW-1:0] m0_rdata,
  output logic [DW-1:0] m1_rdata,
  output logic          s_en,
  output logic          s_we,
  output logic [AW-1:0] s_addr,
  output logic [DW-1:0] s_wdata,
  input  logic [DW-1:0] s_rdata
);

  localparam int            CW      = $clog2(LOCK_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(LOCK_MAX);

  arb_state_t    state;
  arb_state_t    state_nxt;
  logic [CW-1:0] lock_cnt;
  logic [CW-1:0] lock_cnt_nxt;
  logic [CW-1:0] lock_cnt_inc;
  logic          last_gnt;
  logic [1:0]    pick;
  logic          locked_win;
  logic          rd_pend;
  logic          rd_owner;

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR_EN = 1'b1;

  // Remember which master was granted most recently (m0 wins the first tie)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt <= M_LOADER;
    end else if (m0_gnt) begin
      last_gnt <= M_CORE;
    end else if (m1_gnt) begin
      last_gnt <= M_LOADER;
    end
  end
`else
  localparam bit RR_EN = 1'b0;

  assign last_gnt = M_LOADER;
`endif

  rr_pick2 #(
    .ROUND_ROBIN (RR_EN)
  ) u_pick (
    .req  ({m1_req, m0_req}),
    .last (last_gnt),
    .pick (pick)
  );

  // While the loader owns the bus its request beats everything else
  assign locked_win   = (state == ARB_OWN1) && m1_req;
  assign lock_cnt_inc = (lock_cnt == CNT_MAX) ? lock_cnt : lock_cnt + CW'(1);

  // State, lock counter and read-tracking registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ARB_IDLE;
      lock_cnt <= '0;
      rd_pend  <= 1'b0;
      rd_owner <= M_CORE;
    end else begin
      state    <= state_nxt;
      lock_cnt <= lock_cnt_nxt;
      rd_pend  <= s_en && !s_we;
      rd_owner <= m1_gnt ? M_LOADER : M_CORE;
    end
  end

  // Grant selection and next-state / lock-count bookkeeping
  always_comb begin
    m0_gnt       = 1'b0;
    m1_gnt       = 1'b0;
    state_nxt    = state;
    lock_cnt_nxt = lock_cnt;
    if (locked_win) begin
      m1_gnt = 1'b1;
    end else begin
      m0_gnt = pick[0];
      m1_gnt = pick[1];
    end
    case (state)
      ARB_OWN1: begin
        if (m1_gnt) begin
          // Count grants the core has to wait through; release at the bound
          lock_cnt_nxt = m0_req ? lock_cnt_inc : '0;
          if (!m1_lock || (lock_cnt_nxt == CNT_MAX)) begin
            state_nxt = ARB_IDLE;
          end
        end else if (m0_gnt) begin
          lock_cnt_nxt = '0;
          state_nxt    = ARB_OWN0;
        end else begin
          lock_cnt_nxt = '0;
        end
      end
      default: begin
        // IDLE and OWN0 arbitrate identically; OWN0 only marks an m0 grant
        lock_cnt_nxt = '0;
        if (m0_gnt) begin
          state_nxt = ARB_OWN0;
        end else if (m1_gnt && m1_lock) begin
          state_nxt = ARB_OWN1;
        end else begin
          state_nxt = ARB_IDLE;
        end
      end
    endcase
  end

  // RAM-side mux from the granted master; quiet bus when nobody is granted
  always_comb begin
    s_en    = m0_gnt | m1_gnt;
    s_we    = 1'b0;
    s_addr  = '0;
    s_wdata = '0;
    if (m0_gnt) begin
      s_we    = m0_we;
      s_addr  = m0_addr;
      s_wdata = m0_wdata;
    end else if (m1_gnt) begin
      s_we    = m1_we;
      s_addr  = m1_addr;
      s_wdata = m1_wdata;
    end
  end

  assign m0_rvalid = rd_pend && (rd_owner == M_CORE);
  assign m1_rvalid = rd_pend && (rd_owner == M_LOADER);
  assign m0_rdata  = m0_rvalid ? s_rdata : '0;
  assign m1_rdata  = m1_rvalid ? s_rdata : '0;

endmodule

`default_nettype wire
